mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Multi-cycle CPU main control unit. A Moore-style FSM sequences the datapath registers over 3-5 cycles per instruction.
- Generates clock enables for the CE-gated 32-bit registers: PC, IR, MDR.
- Generates mux selects, memory strobes and ALU op class.
- A, B and ALUOut load every cycle and need no enable.
- Stalls on a memory ready handshake.

Parameters:
STATE_W, 4, width of state_o (fixed encoding below)
MEM_WAIT, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from state ID onward
mem_ready  in  1  memory done: read data valid / write accepted this cycle
pc_write  out  1  PC CE, unconditional
pc_write_cond  out  1  PC CE when ALU zero (gated in datapath)
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
i_or_d  out  1  0 PC, 1 ALUOut as memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR CE
mdr_write  out  1  MDR CE
mem_to_reg  out  1  0 ALUOut, 1 MDR to regfile
reg_dst  out  1  0 rt, 1 rd
reg_write  out  1  regfile write enable
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_o  out  STATE_W  current state, for debug display

Behaviour:
- State encoding: IF=0, ID=1, MADDR=2, MRD=3, WBM=4, MWR=5, EXR=6, WBR=7, BEQ=8, J=9, EXI=10, WBI=11. Codes 12-15 are unreachable and go to IF on the next edge with all outputs 0.
- Reset: rst_n low asynchronously forces state to IF. While rst_n=0, every output is 0, including state_o=0 and mem_read. Reset mid-instruction abandons it; no partial write is issued after deassertion. The first active cycle after reset is IF.
- Outputs are decoded from state; "rdy" below denotes mem_ready (or 1 when MEM_WAIT=0). Outputs not listed for a state are 0.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=rdy, pc_write=rdy. Stay in IF while !rdy; go to ID when rdy.
- ID: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by op:
  - 000000 -> EXR
  - 100011 or 101011 -> MADDR
  - 000100 -> BEQ
  - 000010 -> J
  - 001000 -> EXI
  - any other op -> IF, with illegal_op=1 in this ID cycle only
- MADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MRD if op=100011, else MWR.
- MRD: mem_read=1, i_or_d=1, mdr_write=rdy. Hold while !rdy; go to WBM when rdy.
- WBM: reg_write=1, mem_to_reg=1, reg_dst=0. Go to IF.
- MWR: mem_write=1, i_or_d=1. Hold with mem_write asserted while !rdy; go to IF when rdy. Exactly one accepted write per sw.
- EXR: alu_src_a=1, alu_src_b=00, alu_op=10. Go to WBR.
- WBR: reg_write=1, reg_dst=1, mem_to_reg=0. Go to IF.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to IF.
- J: pc_write=1, pc_source=10. Go to IF.
- EXI: alu_src_a=1, alu_src_b=10, alu_op=00. Go to WBI.
- WBI: reg_write=1, reg_dst=0, mem_to_reg=0. Go to IF.
- Latency with zero wait states: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each cycle mem_ready is low in IF, MRD or MWR adds one cycle.
- Write hazard rules:
  - pc_write and ir_write are never high in any state other than IF/J.
  - reg_write and mem_write are never high in the same cycle.
  - op is sampled only in ID and MADDR; IR is stable there because ir_write=0.

Decomposition:
- Package mc_ctrl_pkg holds the state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALU op codes and mux select codes.
- The state register and next-state logic live in mc_ctrl_fsm.
- The state-to-output decode is the natural sub-module: mc_ctrl_decode, purely combinational. Inputs are state and rdy; outputs are all control lines.

Test Plan:
- Reset pulse mid-WBM (rst_n low 2 ns, not edge-aligned) -> all outputs 0 immediately, including reg_write; after release, state_o=0 and mem_read=1.
- op=000000, mem_ready=1 -> state sequence 0,1,6,7,0. reg_write=1 only in cycle 4 with reg_dst=1; ir_write and pc_write=1 only in cycle 1.
- op=100011, mem_ready low for 2 cycles in MRD -> sequence 0,1,2,3,3,3,4,0. mdr_write=1 only in the final MRD cycle; mem_to_reg=1 in WBM.
- op=101011, mem_ready=1 -> sequence 0,1,2,5,0. mem_write=1 for exactly one cycle with i_or_d=1; reg_write never 1.
- op=000100, then op=000010 -> BEQ state has pc_write_cond=1, pc_source=01, alu_op=01. J state has pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- op=111111 -> illegal_op=1 for exactly one cycle in ID, next state IF, no write enable asserted. A forced state code 13 returns to IF next edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle CPU main control unit.
// Holds the fixed state encoding, opcode constants, ALU op class codes, mux
// select codes, the control-line bundle and the opcode legality helper.
`timescale 1ns/1ps
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  // Encoding is fixed: state_o shows these codes on the debug display.
  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBM   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_BEQ   = 4'd8,
    S_J     = 4'd9,
    S_EXI   = 4'd10,
    S_WBI   = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU op class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All state-decoded control lines, so the decoder has one output and the
  // top can zero the whole bundle in reset with a single expression.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the main control unit and the datapath.
//   master modport: the control FSM (receives op/mem_ready, drives controls)
//   slave modport : the datapath/memory side (drives op/mem_ready)
// Signals: op[5:0], mem_ready, pc_write, pc_write_cond, pc_source[1:0],
//   i_or_d, mem_read, mem_write, ir_write, mdr_write, mem_to_reg, reg_dst,
//   reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], illegal_op,
//   state_o[STATE_W-1:0].
`timescale 1ns/1ps
interface mc_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mdr_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mdr_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, illegal_op, state_o
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mdr_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, illegal_op, state_o
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: purely combinational state-to-control decode.
// Ports:
//   state (in)  current FSM state
//   rdy   (in)  memory ready (already forced to 1 when waits are disabled)
//   ctrl  (out) all state-decoded control lines
// Unused state codes decode to all-zero controls.
`timescale 1ns/1ps
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   rdy,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: the full default first means every path assigns every field, so
    // no latch is inferred and unlisted lines are 0 in each state.
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only capture once the fetched word is actually there.
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      S_ID: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MADDR, S_EXI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mdr_write = rdy;
      end
      S_WBM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        // mem_write stays up through wait states; memory accepts it once.
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_WBR: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_J: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_WBI: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle CPU main control unit (Moore FSM).
// Ports:
//   clk   (in) system clock, rising edge
//   rst_n (in) asynchronous active-low reset
//   bus   (mc_ctrl_if.master) op/mem_ready in; PC/IR/MDR enables, mux
//         selects, memory strobes, ALU op class, illegal_op, state_o out
// Parameters:
//   STATE_W  width of state_o (encoding needs 4)
//   MEM_WAIT 1 = stall on mem_ready, 0 = memory always ready
`timescale 1ns/1ps
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_if.master     bus
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;
  logic   rdy;

  assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IF;
    end else begin
      // NOTE: non-blocking assignment for all sequential state, so every
      // flop samples pre-edge values regardless of statement order.
      case (state)
        S_IF:    if (rdy) state <= S_ID;
        S_ID: begin
          case (bus.op)
            OP_RTYPE:     state <= S_EXR;
            OP_LW, OP_SW: state <= S_MADDR;
            OP_BEQ:       state <= S_BEQ;
            OP_J:         state <= S_J;
            OP_ADDI:      state <= S_EXI;
            default:      state <= S_IF;
          endcase
        end
        S_MADDR: state <= (bus.op == OP_LW) ? S_MRD : S_MWR;
        S_MRD:   if (rdy) state <= S_WBM;
        S_MWR:   if (rdy) state <= S_IF;
        S_EXR:   state <= S_WBR;
        S_EXI:   state <= S_WBI;
        S_WBM, S_WBR, S_BEQ, S_J, S_WBI: state <= S_IF;
        // Codes 12-15 are unreachable; recover to fetch.
        default: state <= S_IF;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state (state),
    .rdy   (rdy),
    .ctrl  (dec)
  );

  // The state register already sits at IF during reset, and IF decodes to a
  // memory read; gating with rst_n keeps every line quiet while reset is held.
  assign ctrl = rst_n ? dec : '0;

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mdr_write     = ctrl.mdr_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;

  // Flagged in the ID cycle only; the FSM returns to IF on the next edge.
  assign bus.illegal_op = rst_n && (state == S_ID) && !op_legal(bus.op);

  assign bus.state_o = rst_n ? STATE_W'(state) : '0;

endmodule
